step_debounce: RTL and testbench
================================

STEP_DEBOUNCE -- requirements
Module: step_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the number of consecutive synchronized cycles that commit a level change; legal values are 2 or more.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 0, the auto-repeat period in cycles while held; 0 disables auto-repeat.
REQ-003 SHALL have port clk  input  1  rising-edge system clock, the only clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset), sampled on clk rising edge.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous push-button level (1 = pressed).
REQ-006 SHALL have port step_pulse  output  1  registered one-cycle strobe driving the downstream 3-bit counter's clock/enable.
REQ-007 SHALL have port btn_level  output  1  registered debounced button level.

Function
REQ-008 SHALL pass btn_in through a 2-flop synchronizer; btn_s denotes the second flop output, and no other logic samples btn_in.
REQ-009 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT plus a stability counter cnt and a repeat counter rpt, each wide enough for its parameter.
REQ-010 IDLE: btn_s=1 -> PRESS_WAIT with cnt<=1; else stay, cnt<=0.
REQ-011 PRESS_WAIT: btn_s=0 -> IDLE with cnt<=0; btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, btn_level<=1, step_pulse<=1, rpt<=0; else cnt++.
REQ-012 HELD: btn_s=0 -> RELEASE_WAIT with cnt<=1; else stay and run auto-repeat per REQ-014.
REQ-013 RELEASE_WAIT: btn_s=1 -> HELD with rpt<=0 and no pulse; btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0; else cnt++.
REQ-014 Auto-repeat (REPEAT_CYCLES>0, state HELD, btn_s=1): rpt==REPEAT_CYCLES-1 -> step_pulse<=1, rpt<=0; else rpt++.
REQ-015 step_pulse SHALL be 0 in every cycle not named in REQ-011/REQ-014 and SHALL never be high two consecutive cycles.
REQ-016 Press latency: btn_in high and stable from edge 1 -> step_pulse and btn_level high after edge DEBOUNCE_CYCLES+2 (edge 6 at default).
REQ-017 Release latency: btn_in low and stable from edge 1 (in HELD) -> btn_level low after edge DEBOUNCE_CYCLES+2; release produces no pulse.
REQ-018 A btn_s excursion shorter than DEBOUNCE_CYCLES cycles SHALL change neither output.
REQ-019 Counters SHALL saturate-free by construction: cnt never exceeds DEBOUNCE_CYCLES-1 and rpt never exceeds REPEAT_CYCLES-1; no wrap-around.
REQ-020 btn_level SHALL equal 1 exactly in HELD and RELEASE_WAIT.

Reset
REQ-021 rst=0 at a clk edge SHALL clear both synchronizer flops, state<=IDLE, cnt<=0, rpt<=0, step_pulse<=0, btn_level<=0; rst dominates all other conditions.
REQ-022 Reset SHALL be synchronous only; rst is not in any sensitivity path other than clk.
REQ-023 A button held through reset release SHALL be treated as a new press: pulse after DEBOUNCE_CYCLES+2 edges counted from the first edge with rst=1.
REQ-024 Reset mid-operation (any state) SHALL abort it with no pulse in the reset cycle or the cycle after.

Verification
REQ-025 Reset: btn_in=1, rst=0 for 3 edges -> step_pulse=0, btn_level=0; rst=1 -> pulse at 6th edge after release (D=4).
REQ-026 Clean press, D=4, R=0: btn_in 0->1 held 20 cycles -> exactly one 1-cycle pulse at edge 6, btn_level=1 from edge 6; release -> btn_level=0 at edge 6 after release, no pulse.
REQ-027 Glitch: btn_in high for 3 cycles then low -> no pulse, btn_level stays 0; 4-cycle high -> one pulse.
REQ-028 Release bounce: in HELD, btn_in low 2 cycles then high -> btn_level stays 1, no pulse, state returns to HELD.
REQ-029 Auto-repeat, D=4, R=8: hold 30 cycles past commit -> pulses at commit edge, +8, +16, +24, +32 limited by hold, each 1 cycle wide; downstream 3-bit counter wraps 7->0 correctly.
REQ-030 Reset mid-hold: rst=0 one edge during HELD with R=8 -> outputs 0 next cycle, rpt cleared, next pulse 6 edges after rst=1.

Source files
------------

// File: rtl/step_debounce_if.sv
// Button-side bundle for step_debounce: the raw push-button level in,
// the debounced level and the step strobe out.
interface step_debounce_if;
  logic btn_in;
  logic step_pulse;
  logic btn_level;

  // Driver of the raw button and consumer of the debounced outputs.
  modport master (output btn_in, input step_pulse, btn_level);
  // The debouncer itself.
  modport slave (input btn_in, output step_pulse, btn_level);
endinterface

// File: rtl/step_debounce.sv
// Push-button debouncer with optional auto-repeat. A raw, asynchronous
// button level is synchronized, qualified by DEBOUNCE_CYCLES consecutive
// stable samples, and turned into a registered level plus a one-cycle
// step strobe on every committed press, and every REPEAT_CYCLES while held.
module step_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 0
) (
  input  logic        clk,
  input  logic        rst,
  step_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST =
    RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic             sync_q1;
  logic             btn_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RPT_W-1:0] rpt, rpt_nxt;
  logic             pulse_q, pulse_nxt;
  logic             level_q, level_nxt;

  // Two-flop synchronizer; the only place the raw button is sampled.
  // NOTE: reset is sampled on the clock edge only, and every sequential
  // assignment is non-blocking so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= bus.btn_in;
      btn_s   <= sync_q1;
    end
  end

  // Next-state, counter and output decode for the debounce FSM.
  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rpt_nxt   = rpt;
    pulse_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
          rpt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_W'(1);
        end else if (REPEAT_CYCLES > 0) begin
          if (rpt == RPT_LAST) begin
            pulse_nxt = 1'b1;
            rpt_nxt   = '0;
          end else begin
            rpt_nxt   = rpt + RPT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes the hold without a new step,
        // but restarts the repeat period.
        if (btn_s) begin
          state_nxt = HELD;
          rpt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rpt     <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rpt     <= rpt_nxt;
      pulse_q <= pulse_nxt;
      level_q <= level_nxt;
    end
  end

  assign bus.step_pulse = pulse_q;
  assign bus.btn_level  = level_q;

endmodule

// File: tb/tb_step_debounce.sv
// Self-checking bench for step_debounce. Two instances (no repeat, repeat
// period 8) share one button and reset. A behavioural model describes the
// debouncer as "a delayed sample must disagree with the committed level for
// D consecutive samples to flip it", plus a hold-time phase for repeats.
module tb_step_debounce;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  int   total = 0;
  int   bad   = 0;
  logic [2:0] step_cnt = 3'd0;  // downstream 3-bit counter clocked by dut8

  step_debounce_if if0 ();
  step_debounce_if if8 ();
  assign if0.btn_in = btn;
  assign if8.btn_in = btn;

  step_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  step_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(8)) dut8 (
    .clk (clk), .rst (rst), .bus (if8.slave));

  always #5 clk = ~clk;

  typedef struct {
    bit s1;     // button one edge ago
    bit s2;     // button two edges ago (the synchronized view)
    bit lvl;    // committed debounced level
    int run;    // consecutive samples disagreeing with lvl
    int phase;  // held samples since the last step / repeat restart
    bit pulse;
  } model_t;

  model_t m0 = '{default: 0};
  model_t m8 = '{default: 0};

  function automatic model_t model_step(model_t m, bit b, bit r, int d, int rp);
    model_t n;
    bit     bs;
    n = m;
    if (!r) begin
      n = '{default: 0};
      return n;
    end
    bs    = m.s2;
    n.s2  = m.s1;
    n.s1  = b;
    n.pulse = 1'b0;
    if (bs != n.lvl) begin
      n.run++;
      if (n.run == d) begin
        n.lvl = bs;
        n.run = 0;
        if (bs) begin
          n.pulse = 1'b1;
          n.phase = 0;
        end
      end
    end else begin
      if (n.lvl) begin
        if (n.run > 0) n.phase = 0;  // bounce ended, hold resumes afresh
        else if (rp > 0) begin
          n.phase++;
          if (n.phase == rp) begin
            n.pulse = 1'b1;
            n.phase = 0;
          end
        end
      end
      n.run = 0;
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance the model at each edge and compare every output one unit later.
  always @(posedge clk) begin
    m0 = model_step(m0, btn, rst, D, 0);
    m8 = model_step(m8, btn, rst, D, 8);
    #1;
    check("pulse_r0", if0.step_pulse, m0.pulse);
    check("level_r0", if0.btn_level,  m0.lvl);
    check("pulse_r8", if8.step_pulse, m8.pulse);
    check("level_r8", if8.btn_level,  m8.lvl);
    if (if8.step_pulse === 1'b1) step_cnt = step_cnt + 3'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         npul;
    int         nlvl;
    logic [2:0] snap;
    logic [2:0] diff;
    int         remaining;

    // Reset with the button already held.
    btn = 1'b1;
    rst = 1'b0;
    tick(3);
    check("rst_pulse", if0.step_pulse, 1'b0);
    check("rst_level", if0.btn_level,  1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("rstrel_pulse", if0.step_pulse, (e == 6));
      check("rstrel_level", if0.btn_level,  (e == 6));
    end
    check("model_pin_press", m0.pulse, 1'b1);

    // Release: level drops on the 6th edge, no pulse.
    btn = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("release_level", if0.btn_level,  (e < 6));
      check("release_pulse", if0.step_pulse, 1'b0);
    end
    check("model_pin_release", m0.lvl, 1'b0);
    tick(4);

    // Clean press held 20 cycles, then release.
    btn = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick(1);
      check("press_pulse", if0.step_pulse, (e == 6));
      check("press_level", if0.btn_level,  (e >= 6));
    end
    btn = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("press_rel_level", if0.btn_level,  (e < 6));
      check("press_rel_pulse", if0.step_pulse, 1'b0);
    end
    tick(4);

    // Glitch of 3 cycles: nothing happens.
    npul = 0; nlvl = 0;
    for (int e = 1; e <= 15; e++) begin
      btn = (e <= 3);
      tick(1);
      npul += int'(if0.step_pulse);
      nlvl += int'(if0.btn_level);
    end
    check("glitch3_pulses", npul, 0);
    check("glitch3_level",  nlvl, 0);

    // 4-cycle press: exactly one step.
    npul = 0;
    for (int e = 1; e <= 15; e++) begin
      btn = (e <= 4);
      tick(1);
      npul += int'(if0.step_pulse);
    end
    check("press4_pulses", npul, 1);
    check("press4_level_end", if0.btn_level, 1'b0);

    // Release bounce while held: level stays 1, no pulse.
    btn = 1'b1;
    tick(10);
    npul = 0; nlvl = 0;
    for (int e = 1; e <= 14; e++) begin
      btn = !(e == 1 || e == 2);
      tick(1);
      npul += int'(if0.step_pulse);
      nlvl += int'(if0.btn_level);
    end
    check("bounce_pulses", npul, 0);
    check("bounce_level",  nlvl, 14);
    btn = 1'b0;
    tick(10);

    // Auto-repeat: 90-edge hold gives steps at 6, 14, ..., 86 = 11 pulses;
    // the 3-bit counter wraps and ends 3 past where it started.
    snap = step_cnt;
    npul = 0;
    btn  = 1'b1;
    for (int e = 1; e <= 90; e++) begin
      tick(1);
      check("repeat_pulse", if8.step_pulse, (e >= 6 && ((e - 6) % 8) == 0));
      npul += int'(if8.step_pulse);
    end
    btn = 1'b0;
    tick(10);
    check("repeat_count", npul, 11);
    diff = step_cnt - snap;
    check("repeat_wrap", diff, 3'd3);

    // Reset mid-hold with repeat enabled.
    btn = 1'b1;
    tick(10);
    rst = 1'b0;
    tick(1);
    check("midrst_pulse", if8.step_pulse, 1'b0);
    check("midrst_level", if8.btn_level,  1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick(1);
      check("midrst_repress", if8.step_pulse, (e == 6));
    end
    btn = 1'b0;
    tick(10);

    // Random bursts of stable levels with occasional resets.
    remaining = 0;
    for (int i = 0; i < 3000; i++) begin
      if (remaining == 0) begin
        btn       = 1'($urandom_range(0, 1));
        remaining = $urandom_range(1, 12);
      end
      remaining--;
      rst = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
